// File: rtl/temporal_mxu.sv
// Temporal-unary matrix multiplier: out = A x B, one output row per
// 2^BIT_WIDTH-cycle pass, with A elements streamed as unary pulse trains.
module temporal_mxu #(
  parameter int BIT_WIDTH = 4,
  parameter int DIM       = 2
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        start,
  input  logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]      A,
  input  logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]      B,
  output logic                                        out_valid,
  output logic [DIM-1:0][DIM-1:0][2*BIT_WIDTH-1:0]    out,
  output logic [1:0]                                  fsm_state_o
);

  localparam int OW = 2 * BIT_WIDTH;
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [BIT_WIDTH-1:0] T_LAST = BIT_WIDTH'((1 << BIT_WIDTH) - 2);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // Handshake: start is a one-cycle request honoured only in IDLE/DONE;
  // out_valid stays high with out stable until reset or the next start.
  logic [1:0]                               state_q, state_d;
  logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [DIM-1:0][DIM-1:0][OW-1:0]          acc_q, acc_d;
  logic [DIM-1:0][DIM-1:0][OW-1:0]          out_q, out_d;
  logic [IW-1:0]                            i_q, i_d;
  logic [BIT_WIDTH-1:0]                     t_q, t_d;
  logic                                     valid_q, valid_d;

  logic [0:DIM][DIM-1:0][OW-1:0]            intermediate_data_cur;
  logic [OW-1:0]                            run_sum;

  // Column sums across k: entry m holds the sum of acc[0..m-1][j].
  always_comb begin
    intermediate_data_cur = '0;
    run_sum               = '0;
    for (int j = 0; j < DIM; j++) begin
      run_sum = '0;
      for (int k = 0; k < DIM; k++) begin
        intermediate_data_cur[k][j] = run_sum;
        run_sum = run_sum + acc_q[k][j];
      end
      intermediate_data_cur[DIM][j] = run_sum;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    i_d     = i_q;
    t_d     = t_q;
    valid_d = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          out_d   = '0;
          i_d     = '0;
          t_d     = '0;
          valid_d = 1'b0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // Unary bit for A[i][k] is high for the first A[i][k] phases.
        for (int k = 0; k < DIM; k++) begin
          for (int j = 0; j < DIM; j++) begin
            if (t_q < a_q[i_q][k]) begin
              acc_d[k][j] = acc_q[k][j] + OW'(b_q[k][j]);
            end
          end
        end
        t_d = t_q + 1'b1;
        if (t_q == T_LAST) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        for (int j = 0; j < DIM; j++) begin
          out_d[i_q][j] = intermediate_data_cur[DIM][j];
        end
        acc_d = '0;
        t_d   = '0;
        i_d   = i_q + 1'b1;
        if (i_q == IW'(DIM - 1)) begin
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = COMPUTE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      i_q     <= '0;
      t_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      i_q     <= i_d;
      t_q     <= t_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid   = valid_q;
  assign out         = out_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_temporal_mxu.sv
// Bench for temporal_mxu at default parameters: directed table, latency,
// restart, mid-run reset and randomized products against a matrix model.
module tb_temporal_mxu;

  localparam int BW  = 4;
  localparam int DIM = 2;
  localparam int W   = DIM * DIM * 2 * BW;

  typedef logic [DIM-1:0][DIM-1:0][BW-1:0]   mat_t;
  typedef logic [DIM-1:0][DIM-1:0][2*BW-1:0] res_t;
  typedef struct {
    mat_t  a;
    mat_t  b;
    res_t  exp;
    string name;
  } vec_t;

  logic clk;
  logic reset_n;
  logic start;
  mat_t A;
  mat_t B;
  logic out_valid;
  res_t out;
  logic [1:0] fsm_state_o;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  res_t last_exp;

  temporal_mxu #(.BIT_WIDTH(BW), .DIM(DIM)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out        (out),
    .fsm_state_o(fsm_state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic mat_t mk(input int a00, input int a01, input int a10, input int a11);
    mat_t m;
    m[0][0] = 4'(a00); m[0][1] = 4'(a01);
    m[1][0] = 4'(a10); m[1][1] = 4'(a11);
    return m;
  endfunction

  function automatic res_t mk_r(input int c00, input int c01, input int c10, input int c11);
    res_t r;
    r[0][0] = 8'(c00); r[0][1] = 8'(c01);
    r[1][0] = 8'(c10); r[1][1] = 8'(c11);
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[r][c] = 4'($urandom_range(0, 15));
    return m;
  endfunction

  // Reference: ordinary matrix product, truncated to the output width.
  function automatic res_t model(input mat_t a, input mat_t b);
    res_t r;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        int s = 0;
        for (int k = 0; k < DIM; k++) s += int'(a[i][k]) * int'(b[k][j]);
        r[i][j] = 8'(s % 256);
      end
    return r;
  endfunction

  // One full operation; expected product must already be queued.
  task automatic run_op(input mat_t a, input mat_t b, input string name, input int glitch_at);
    res_t exp;
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_start_clr_valid"}, 64'(out_valid), 64'd0);
    check({name, "_start_clr_out"}, 64'(out), 64'd0);
    for (int c = 0; c < 15; c++) begin
      A = rand_mat(); B = rand_mat();
      if (c == glitch_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    exp = res_t'(exp_q[0]);
    check({name, "_row0_sum"}, 64'(dut.intermediate_data_cur[DIM]), 64'(exp[0]));
    repeat (16) tick();
    check({name, "_valid_not_early"}, 64'(out_valid), 64'd0);
    tick();
    check({name, "_valid_at_32"}, 64'(out_valid), 64'd1);
    check({name, "_out"}, 64'(out), 64'(exp_q.pop_front()));
    check({name, "_state_done"}, 64'(fsm_state_o), 64'd3);
    last_exp = exp;
  endtask

  vec_t vecs[4];

  initial begin
    mat_t ra, rb;
    vecs[0] = '{a: mk(2, 8, 12, 14), b: mk(6, 12, 12, 9), exp: mk_r(108, 96, 240, 14), name: "spec_example"};
    vecs[1] = '{a: mk(1, 0, 0, 1), b: mk(3, 7, 9, 15), exp: mk_r(3, 7, 9, 15), name: "identity"};
    vecs[2] = '{a: mk(15, 15, 15, 15), b: mk(15, 15, 15, 15), exp: mk_r(194, 194, 194, 194), name: "all_max"};
    vecs[3] = '{a: mk(0, 0, 0, 0), b: mk(0, 0, 0, 0), exp: mk_r(0, 0, 0, 0), name: "all_zero"};

    reset_n = 1'b1; start = 1'b0; A = '0; B = '0;
    tick(); tick();
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_out", 64'(out), 64'd0);
    check("reset_state", 64'(fsm_state_o), 64'd0);
    reset_n = 1'b0;
    tick();

    // Directed table; every op after the first restarts from DONE.
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(W'(vecs[v].exp));
      run_op(vecs[v].a, vecs[v].b, vecs[v].name, -1);
    end

    // DONE holds its result while start stays low.
    for (int c = 0; c < 3; c++) begin
      A = rand_mat(); B = rand_mat();
      tick();
      check("done_hold_valid", 64'(out_valid), 64'd1);
      check("done_hold_out", 64'(out), 64'(last_exp));
    end

    // Start re-pulsed mid-COMPUTE must be ignored.
    ra = mk(2, 8, 12, 14); rb = mk(6, 12, 12, 9);
    exp_q.push_back(W'(model(ra, rb)));
    run_op(ra, rb, "start_glitch", 5);

    // Reset 10 cycles into a run aborts it; reset also overrides start.
    A = mk(3, 4, 5, 6); B = mk(7, 8, 9, 10); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset_n = 1'b1; start = 1'b1;
    tick();
    reset_n = 1'b0; start = 1'b0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_out", 64'(out), 64'd0);
    check("abort_state_idle", 64'(fsm_state_o), 64'd0);
    tick();
    check("abort_stays_idle", 64'(fsm_state_o), 64'd0);
    ra = mk(9, 1, 4, 13); rb = mk(11, 2, 15, 6);
    exp_q.push_back(W'(model(ra, rb)));
    run_op(ra, rb, "after_abort", -1);

    // Randomized products, with extreme operands mixed in.
    for (int n = 0; n < 8; n++) begin
      ra = rand_mat(); rb = rand_mat();
      if (n % 3 == 0) ra[n % 2][1] = 4'd15;
      if (n % 4 == 1) rb[1][n % 2] = 4'd0;
      exp_q.push_back(W'(model(ra, rb)));
      run_op(ra, rb, $sformatf("rand%0d", n), (n % 2 == 0) ? int'($urandom_range(0, 14)) : -1);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temporal_mxu.md
TEMPORAL_MXU -- requirements
Module: temporal_mxu

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4, the unsigned operand width in bits.
REQ-002 SHALL have parameter DIM, default 2, the square matrix dimension; A is DIM x DIM, B is DIM x DIM, out is DIM x DIM.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  synchronous reset; asserted when 1 despite the name.
REQ-006 start  input  1  single-cycle request to compute out = A x B.
REQ-007 A  input  [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]  packed A[row][col], unsigned.
REQ-008 B  input  [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]  packed B[row][col], unsigned.
REQ-009 out_valid  output  1  high while out holds a completed product.
REQ-010 out  output  [DIM-1:0][DIM-1:0][2*BIT_WIDTH-1:0]  registered product C[row][col].
REQ-011 SHALL expose internal signal intermediate_data_cur [0:DIM][DIM-1:0][2*BIT_WIDTH-1:0] at the hierarchy top for bench probing.

Function
REQ-012 SHALL have FSM states IDLE, COMPUTE, WRITE, DONE.
REQ-013 IDLE/DONE with start=1 SHALL latch A and B, clear out_valid, out and accumulators, set row index i=0 and phase counter t=0, and go to COMPUTE.
REQ-014 start SHALL be ignored in COMPUTE and WRITE; latched operands SHALL NOT change mid-operation.
REQ-015 COMPUTE SHALL last exactly 2^BIT_WIDTH-1 cycles (t = 0 .. 2^BIT_WIDTH-2), with t incrementing each cycle.
REQ-016 In COMPUTE, each k SHALL form a temporal unary bit u[k] = (t < A[i][k]), and each acc[k][j] SHALL add B[k][j] when u[k]=1, so acc[k][j] = A[i][k]*B[k][j] at phase end.
REQ-017 intermediate_data_cur[0][j] SHALL be 0, and intermediate_data_cur[k+1][j] SHALL equal intermediate_data_cur[k][j] + acc[k][j] (combinational, 2*BIT_WIDTH bits).
REQ-018 WRITE (1 cycle) SHALL load out[i][j] from intermediate_data_cur[DIM][j] for all j, clear acc and t, and increment i.
REQ-019 After WRITE, if i was DIM-1 the FSM SHALL go to DONE with out_valid=1, otherwise it SHALL return to COMPUTE.
REQ-020 All sums SHALL be truncated modulo 2^(2*BIT_WIDTH), with no saturation or overflow flag.
REQ-021 Latency: out_valid SHALL rise DIM*2^BIT_WIDTH clock edges after the edge that samples start (32 for the defaults).
REQ-022 DONE SHALL hold out and out_valid stable until reset or a new start.
REQ-023 An operand of 0 SHALL produce no unary pulses; an operand of 2^BIT_WIDTH-1 SHALL pulse for every COMPUTE cycle.

Reset
REQ-024 reset_n=1 at a clock edge SHALL force IDLE, out_valid=0, out=0, acc=0, i=0, t=0, and this SHALL override start.
REQ-025 Reset mid-COMPUTE/WRITE SHALL abort without updating out; a later start SHALL begin a fresh computation.

Verification
REQ-026 Defaults, A=[[2,8],[12,14]], B=[[6,12],[12,9]], one start pulse -> out=[[108,96],[240,14]] (270 wraps to 14), out_valid high 32 edges after start.
REQ-027 A=[[1,0],[0,1]], B=[[3,7],[9,15]] -> out=[[3,7],[9,15]].
REQ-028 All A and B = 15 -> every out element = 194 (450 mod 256); all zeros -> out all 0 with out_valid=1.
REQ-029 start re-pulsed during COMPUTE with different A -> ignored, original product returned at the same cycle.
REQ-030 Reset asserted 10 cycles after start -> out_valid=0 and out=0; a new start then yields a correct product after 32 edges.
REQ-031 Restart from DONE -> out_valid drops on the start edge, then rises again 32 edges later with the new product.
